res_bank_pwl: RTL

RES_BANK_PWL -- requirements
Module: res_bank_pwl

---
 rtl/res_bank_pkg.sv | 30 +++
 rtl/res_bank_ch.sv | 85 ++++++++
 rtl/res_bank_pwl.sv | 110 +++++++++++
 3 files changed

// File: rtl/res_bank_pkg.sv
// Shared types and defaults for the resistor bank: piecewise-linear signal
// record, configuration FSM states, default parameter values and the
// code-to-resistance mapping.
package res_bank_pkg;

    // Piecewise-linear sample: value a, slope b, timestamp t.
    typedef struct {
        real a;
        real b;
        real t;
    } pwl_t;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } cfg_state_e;

    localparam int  NCH_DEF        = 4;
    localparam int  CODE_W_DEF     = 6;
    localparam real R_STEP_DEF     = 10.0;
    localparam real R_OFF_DEF      = 100.0;
    localparam real VMAX_DEF       = 1.5;
    localparam int  SETTLE_CYC_DEF = 4;
    localparam int  CNT_W_DEF      = 8;

    function automatic real code_to_r(input int code, input real r_off, input real r_step);
        return r_off + r_step * real'(code);
    endfunction

endpackage

// File: rtl/res_bank_ch.sv
// One resistor channel: scales the branch current by the active resistance,
// clamps the voltage to +/-VMAX and counts clamp entries.
// Optional feature macro: RES_BANK_CLAMP_CNT_EN enables the clamp counter;
// without it clamp_cnt is tied to zero and no counter storage exists.
module res_bank_ch
    import res_bank_pkg::*;
#(
    parameter int  CODE_W = CODE_W_DEF,
    parameter int  CNT_W  = CNT_W_DEF,
    parameter real R_STEP = R_STEP_DEF,
    parameter real R_OFF  = R_OFF_DEF,
    parameter real VMAX   = VMAX_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  pwl_t              i_in,
    output pwl_t              v_out,
    output logic              clamp_flag,
    output logic [CNT_W-1:0]  clamp_cnt
);

    real  r_c;
    real  va_c;
    pwl_t v_d;
    pwl_t v_q;
    logic flag_d;
    logic flag_q;

    // Ohmic scaling with symmetric clamp; the slope is dropped while clamped.
    always_comb begin
        r_c    = code_to_r(int'(code), R_OFF, R_STEP);
        va_c   = r_c * i_in.a;
        v_d.a  = va_c;
        v_d.b  = r_c * i_in.b;
        v_d.t  = i_in.t;
        flag_d = 1'b0;
        if ((va_c > VMAX) || (va_c < -VMAX)) begin
            v_d.a  = (i_in.a < 0.0) ? -VMAX : VMAX;
            v_d.b  = 0.0;
            flag_d = 1'b1;
        end
    end

    // Output register; under reset the timestamp still tracks the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '{a: 0.0, b: 0.0, t: i_in.t};
            flag_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            flag_q <= flag_d;
        end
    end

    assign v_out      = v_q;
    assign clamp_flag = flag_q;

`ifdef RES_BANK_CLAMP_CNT_EN
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Count each entry into clamp, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (flag_d && !flag_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Clamp event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clamp_cnt = cnt_q;
`else
    assign clamp_cnt = '0;
`endif

endmodule

// File: rtl/res_bank_pwl.sv
// Resistor bank top: per-channel resistance codes updated through a
// two-state settle FSM, feeding NCH scaling/clamp channels.
// Optional feature macro: RES_BANK_CLAMP_CNT_EN (per-channel clamp counters).
// cfg_ch carries one bit beyond $clog2(NCH) so that out-of-range channel
// numbers are representable; such requests settle but write nothing.
module res_bank_pwl
    import res_bank_pkg::*;
#(
    parameter int  NCH        = NCH_DEF,
    parameter int  CODE_W     = CODE_W_DEF,
    parameter real R_STEP     = R_STEP_DEF,
    parameter real R_OFF      = R_OFF_DEF,
    parameter real VMAX       = VMAX_DEF,
    parameter int  SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int  CNT_W      = CNT_W_DEF
)(
    input  logic                   clk,
    input  logic                   rst,
    input  pwl_t                   i_in [NCH],
    output pwl_t                   v_out [NCH],
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [$clog2(NCH):0]   cfg_ch,
    input  logic [CODE_W-1:0]      cfg_code,
    output logic [NCH-1:0]         clamp_flag,
    output logic [NCH*CNT_W-1:0]   clamp_cnt
);

    localparam int CH_W = $clog2(NCH) + 1;
    localparam int SC_W = $clog2(SETTLE_CYC + 1);

    cfg_state_e        state_d, state_q;
    logic [SC_W-1:0]   scnt_d, scnt_q;
    logic [CH_W-1:0]   lat_ch_d, lat_ch_q;
    logic [CODE_W-1:0] lat_code_d, lat_code_q;
    logic [CODE_W-1:0] code_d [NCH];
    logic [CODE_W-1:0] code_q [NCH];

    // Config FSM: latch a request in IDLE, count down in SETTLE, then apply.
    always_comb begin
        state_d    = state_q;
        scnt_d     = scnt_q;
        lat_ch_d   = lat_ch_q;
        lat_code_d = lat_code_q;
        code_d     = code_q;
        cfg_ready  = (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    lat_ch_d   = cfg_ch;
                    lat_code_d = cfg_code;
                    scnt_d     = SC_W'(SETTLE_CYC);
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (scnt_q <= SC_W'(1)) begin
                    scnt_d  = '0;
                    state_d = IDLE;
                    for (int i = 0; i < NCH; i++) begin
                        if (lat_ch_q == CH_W'(i)) begin
                            code_d[i] = lat_code_q;
                        end
                    end
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Config state and code table; reset drops any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scnt_q     <= '0;
            lat_ch_q   <= '0;
            lat_code_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                code_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            scnt_q     <= scnt_d;
            lat_ch_q   <= lat_ch_d;
            lat_code_q <= lat_code_d;
            code_q     <= code_d;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        res_bank_ch #(
            .CODE_W (CODE_W),
            .CNT_W  (CNT_W),
            .R_STEP (R_STEP),
            .R_OFF  (R_OFF),
            .VMAX   (VMAX)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .code       (code_q[g]),
            .i_in       (i_in[g]),
            .v_out      (v_out[g]),
            .clamp_flag (clamp_flag[g]),
            .clamp_cnt  (clamp_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule
